// File: rtl/mawg_cmd_if.sv
// UART-side and register-side signals of the MAWG command controller.
// master = controller, slave = the UART/register environment.
interface mawg_cmd_if;
  logic        rx_busy;
  logic [7:0]  rx_data;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        clear_all;
  logic [7:0]  err_cnt;
  logic        idle;

  modport master (
    input  rx_busy, rx_data, tx_busy,
    output tx_start, tx_data, wr_en, wr_addr, wr_data, clear_all, err_cnt, idle
  );
  modport slave (
    output rx_busy, rx_data, tx_busy,
    input  tx_start, tx_data, wr_en, wr_addr, wr_data, clear_all, err_cnt, idle
  );
endinterface

// File: rtl/mawg_cmd_ctrl.sv
// Framed UART command parser: SYNC, CMD, D3..D0, CSUM -> register write or
// clear-all, then ACK/NAK back through the UART_TX handshake.
module mawg_cmd_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] ACK_BYTE  = 8'h06,
  parameter logic [7:0] NAK_BYTE  = 8'h15,
  parameter int         TIMEOUT   = 2000,
  parameter int         MAX_CMD   = 12
) (
  input  logic       clk,
  input  logic       rst,
  mawg_cmd_if.master bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_SYNC, S_CMD, S_DATA, S_CSUM, S_EXEC, S_RESP, S_TXW
  } state_t;

  state_t        state;
  logic          prev_busy;
  logic [7:0]    cmd;
  logic [7:0]    csum_acc;
  logic [7:0]    resp;
  logic [31:0]   data;
  logic [1:0]    byte_cnt;
  logic          tx_seen;
  logic [TW-1:0] tmo_cnt;

  logic rx_evt, in_frame, tmo_hit, csum_ok, cmd_wr, cmd_clr;
  assign rx_evt   = prev_busy & ~bus.rx_busy;
  assign in_frame = (state == S_CMD) || (state == S_DATA) || (state == S_CSUM);
  assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT - 1));
  assign csum_ok  = (bus.rx_data == csum_acc);
  assign cmd_wr   = (cmd <= 8'(MAX_CMD));
  assign cmd_clr  = (cmd == 8'd15);
  assign bus.idle = (state == S_SYNC);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_SYNC;
      prev_busy     <= 1'b0;
      cmd           <= '0;
      csum_acc      <= '0;
      resp          <= '0;
      data          <= '0;
      byte_cnt      <= '0;
      tx_seen       <= 1'b0;
      tmo_cnt       <= '0;
      bus.tx_start  <= 1'b0;
      bus.tx_data   <= '0;
      bus.wr_en     <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
      bus.clear_all <= 1'b0;
      bus.err_cnt   <= '0;
    end else begin
      prev_busy     <= bus.rx_busy;
      bus.wr_en     <= 1'b0;
      bus.clear_all <= 1'b0;
      bus.tx_start  <= 1'b0;
      case (state)
        S_SYNC: begin
          tmo_cnt <= '0;
          if (rx_evt && bus.rx_data == SYNC_BYTE) state <= S_CMD;
        end
        S_CMD: if (rx_evt) begin
          cmd      <= bus.rx_data;
          csum_acc <= bus.rx_data;
          byte_cnt <= '0;
          state    <= S_DATA;
        end
        S_DATA: if (rx_evt) begin
          data     <= {data[23:0], bus.rx_data};
          csum_acc <= csum_acc ^ bus.rx_data;
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) state <= S_CSUM;
        end
        // Strobes are registered here so they are high during the S_EXEC cycle.
        S_CSUM: if (rx_evt) begin
          state <= S_EXEC;
          if (csum_ok && cmd_wr) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= cmd[3:0];
            bus.wr_data <= data;
            resp        <= ACK_BYTE;
          end else if (csum_ok && cmd_clr) begin
            bus.clear_all <= 1'b1;
            resp          <= ACK_BYTE;
          end else begin
            resp        <= NAK_BYTE;
            bus.err_cnt <= sat_inc(bus.err_cnt);
          end
        end
        S_EXEC: state <= S_RESP;
        S_RESP: if (!bus.tx_busy) begin
          bus.tx_start <= 1'b1;
          bus.tx_data  <= resp;
          tx_seen      <= 1'b0;
          tmo_cnt      <= '0;
          state        <= S_TXW;
        end
        // Give up on the TX handshake if busy never rises; no error is counted.
        S_TXW: begin
          if (!tx_seen) begin
            if (bus.tx_busy)  tx_seen <= 1'b1;
            else if (tmo_hit) state   <= S_SYNC;
            else              tmo_cnt <= tmo_cnt + TW'(1);
          end else if (!bus.tx_busy) begin
            state <= S_SYNC;
          end
        end
        default: state <= S_SYNC;
      endcase

      // Inter-byte watchdog inside a frame; aborts silently with an error count.
      if (in_frame) begin
        if (rx_evt) tmo_cnt <= '0;
        else if (tmo_hit) begin
          state       <= S_SYNC;
          tmo_cnt     <= '0;
          bus.err_cnt <= sat_inc(bus.err_cnt);
        end else tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end
endmodule

// File: tb/tb_mawg_cmd_ctrl.sv
// Directed bench for mawg_cmd_ctrl: table of frames plus multi-cycle corner cases.
module tb_mawg_cmd_ctrl;
  localparam int TMO = 2000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mawg_cmd_if bus();
  mawg_cmd_ctrl #(.TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, errors = 0;
  int wr_pulses = 0, clr_pulses = 0, starts = 0;
  int tx_hold = 3;
  logic tx_model = 1'b0, tx_force = 1'b0;
  logic [7:0] last_tx = 8'h00;

  assign bus.tx_busy = tx_model | tx_force;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) wr_pulses++;
    if (bus.clear_all === 1'b1) clr_pulses++;
  end

  // UART_TX model: raise busy for tx_hold cycles after each tx_start.
  always begin
    @(negedge clk);
    if (bus.tx_start === 1'b1) begin
      starts++;
      last_tx = bus.tx_data;
      tx_model = 1'b1;
      repeat (tx_hold) @(negedge clk);
      tx_model = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_busy = 1'b1;
    repeat (2) @(negedge clk);
    bus.rx_busy = 1'b0;
  endtask

  // Sends a full frame and checks the strobes one cycle after the CSUM byte event.
  task automatic send_frame(input logic [7:0] c, input logic [31:0] d, input logic [7:0] cs,
                            input logic ewr, input logic eclr);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(d[31:24]);
    send_byte(d[23:16]);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
    send_byte(cs);
    @(negedge clk);
    check("wr_en_timing", {31'd0, bus.wr_en}, {31'd0, ewr});
    check("clear_all_timing", {31'd0, bus.clear_all}, {31'd0, eclr});
  endtask

  task automatic wait_resp(input int s0);
    for (int i = 0; i < 300 && starts == s0; i++) @(negedge clk);
    check("tx_start_seen", starts - s0, 1);
    for (int i = 0; i < 300 && bus.idle !== 1'b1; i++) @(negedge clk);
    check("idle_after_resp", {31'd0, bus.idle}, 1);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] data;
    logic [7:0]  cs;
    int          wr;
    int          clr;
    logic [7:0]  tx;
    logic [7:0]  err;
    logic [3:0]  addr;
    logic [31:0] wdata;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int w0, c0, s0;
    logic [7:0] e0;
    tbl[0] = '{8'h02, 32'h000186A0, 8'h25, 1, 0, 8'h06, 8'd0, 4'h2, 32'h000186A0};
    tbl[1] = '{8'h02, 32'h000186A0, 8'h26, 0, 0, 8'h15, 8'd1, 4'h2, 32'h000186A0};
    tbl[2] = '{8'h0F, 32'h00000000, 8'h0F, 0, 1, 8'h06, 8'd1, 4'h2, 32'h000186A0};
    tbl[3] = '{8'h0D, 32'h12345678, 8'h05, 0, 0, 8'h15, 8'd2, 4'h2, 32'h000186A0};
    tbl[4] = '{8'h0C, 32'hDEADBEEF, 8'h2E, 1, 0, 8'h06, 8'd2, 4'hC, 32'hDEADBEEF};
    tbl[5] = '{8'h00, 32'hA5A5A5A5, 8'h00, 1, 0, 8'h06, 8'd2, 4'h0, 32'hA5A5A5A5};
    tbl[6] = '{8'h10, 32'h00000001, 8'h11, 0, 0, 8'h15, 8'd3, 4'h0, 32'hA5A5A5A5};

    rst = 1'b1;
    bus.rx_busy = 1'b0;
    bus.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_idle", {31'd0, bus.idle}, 1);
    check("rst_wr_en", {31'd0, bus.wr_en}, 0);
    check("rst_tx_start", {31'd0, bus.tx_start}, 0);
    check("rst_err_cnt", {24'd0, bus.err_cnt}, 0);
    check("rst_wr_data", bus.wr_data, 0);
    rst = 1'b0;

    // Junk outside a frame is ignored without an error.
    send_byte(8'h33);
    repeat (2) @(negedge clk);
    check("junk_idle", {31'd0, bus.idle}, 1);
    check("junk_err", {24'd0, bus.err_cnt}, 0);

    for (int i = 0; i < 7; i++) begin
      w0 = wr_pulses; c0 = clr_pulses; s0 = starts;
      send_frame(tbl[i].cmd, tbl[i].data, tbl[i].cs, tbl[i].wr[0], tbl[i].clr[0]);
      wait_resp(s0);
      check($sformatf("v%0d_wr_cnt", i), wr_pulses - w0, tbl[i].wr);
      check($sformatf("v%0d_clr_cnt", i), clr_pulses - c0, tbl[i].clr);
      check($sformatf("v%0d_tx", i), {24'd0, last_tx}, {24'd0, tbl[i].tx});
      check($sformatf("v%0d_err", i), {24'd0, bus.err_cnt}, {24'd0, tbl[i].err});
      check($sformatf("v%0d_addr", i), {28'd0, bus.wr_addr}, {28'd0, tbl[i].addr});
      check($sformatf("v%0d_wdata", i), bus.wr_data, tbl[i].wdata);
    end

    // Response is held off while UART_TX is busy.
    tx_force = 1'b1;
    s0 = starts;
    send_frame(8'h04, 32'h00000044, 8'h40, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check("resp_held_start", starts - s0, 0);
    check("resp_held_idle", {31'd0, bus.idle}, 0);
    tx_force = 1'b0;
    wait_resp(s0);
    check("resp_held_tx", {24'd0, last_tx}, 32'h06);

    // Inter-byte timeout after A5 03.
    e0 = bus.err_cnt; s0 = starts; w0 = wr_pulses;
    send_byte(8'hA5);
    send_byte(8'h03);
    repeat (TMO - 2) @(negedge clk);
    check("tmo_not_yet", {31'd0, bus.idle}, 0);
    repeat (4) @(negedge clk);
    check("tmo_idle", {31'd0, bus.idle}, 1);
    check("tmo_err", {24'd0, bus.err_cnt}, {24'd0, e0 + 8'd1});
    check("tmo_no_tx", starts - s0, 0);
    check("tmo_no_wr", wr_pulses - w0, 0);
    s0 = starts;
    send_frame(8'h02, 32'h000186A0, 8'h25, 1'b1, 1'b0);
    wait_resp(s0);
    check("tmo_next_tx", {24'd0, last_tx}, 32'h06);
    check("tmo_next_addr", {28'd0, bus.wr_addr}, 2);

    // Second frame lands while TX is busy and is dropped.
    tx_hold = 50;
    w0 = wr_pulses; s0 = starts; e0 = bus.err_cnt;
    send_frame(8'h05, 32'h00000055, 8'h50, 1'b1, 1'b0);
    send_frame(8'h06, 32'h00000066, 8'h60, 1'b0, 1'b0);
    for (int i = 0; i < 300 && !(bus.idle === 1'b1 && tx_model == 1'b0); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("b2b_wr_cnt", wr_pulses - w0, 1);
    check("b2b_starts", starts - s0, 1);
    check("b2b_addr", {28'd0, bus.wr_addr}, 5);
    check("b2b_data", bus.wr_data, 32'h55);
    check("b2b_err", {24'd0, bus.err_cnt}, {24'd0, e0});
    tx_hold = 3;

    // Reset after the D1 byte: async return to reset values, no partial write.
    w0 = wr_pulses; s0 = starts;
    send_byte(8'hA5);
    send_byte(8'h07);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_idle", {31'd0, bus.idle}, 1);
    check("mid_rst_err", {24'd0, bus.err_cnt}, 0);
    check("mid_rst_tx_data", {24'd0, bus.tx_data}, 0);
    check("mid_rst_wr_data", bus.wr_data, 0);
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h44);
    send_byte(8'h44);
    repeat (3) @(negedge clk);
    check("mid_rst_no_wr", wr_pulses - w0, 0);
    check("mid_rst_no_tx", starts - s0, 0);
    check("mid_rst_idle2", {31'd0, bus.idle}, 1);

    // 300 NAK frames saturate the error counter.
    for (int i = 0; i < 300; i++) begin
      s0 = starts;
      send_frame(8'h01, 32'h00000000, 8'h00, 1'b0, 1'b0);
      wait_resp(s0);
      if (i == 253) check("sat_254", {24'd0, bus.err_cnt}, 254);
    end
    check("sat_255", {24'd0, bus.err_cnt}, 255);
    check("sat_tx", {24'd0, last_tx}, 32'h15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mawg_cmd_ctrl.md
Name: mawg_cmd_ctrl

Overview:
- Framed UART command controller for the MAWG configuration register set. Replaces the ad-hoc byte counter in the top level.
- Parses sync/cmd/data/checksum frames from UART_RX and issues single-cycle register writes.
- Returns an ACK/NAK byte through a UART_TX handshake.
- Sits between UART_RX/UART_TX and the top-level MAWG config registers, in the 1 MHz UART clock domain.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker
- ACK_BYTE, 8'h06, response for an accepted frame
- NAK_BYTE, 8'h15, response for a bad checksum or unknown cmd
- TIMEOUT, 2000, idle cycles allowed between bytes inside a frame before abort
- MAX_CMD, 12, highest ordinary register command index

Ports:
- clk  in  1  UART-domain clock
- rst  in  1  asynchronous active-high reset
- rx_busy  in  1  UART_RX busy; falling edge marks a received byte
- rx_data  in  8  UART_RX byte, valid on the rx_busy falling edge
- tx_busy  in  1  UART_TX busy
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data
- tx_data  out  8  response byte
- wr_en  out  1  one-cycle register write strobe
- wr_addr  out  4  register index (cmd[3:0])
- wr_data  out  32  write value, big-endian assembled
- clear_all  out  1  one-cycle pulse: zero all MAWG config registers (cmd 15)
- err_cnt  out  8  saturating count of aborted/NAKed frames
- idle  out  1  high in S_SYNC

Behaviour:
- Reset (async) values:
  - All outputs 0, except idle = 1.
  - Internal: state S_SYNC, prev_busy = 0, buffers 0, timeout counter 0.
- Byte event: rx_evt = prev_busy & ~rx_busy. prev_busy is registered every cycle.
- Frame format: SYNC, CMD, D3, D2, D1, D0, CSUM, where CSUM = CMD ^ D3 ^ D2 ^ D1 ^ D0.
- States:
  - S_SYNC: on rx_evt with rx_data == SYNC_BYTE, go to S_CMD; any other byte is ignored, no error.
  - S_CMD: on rx_evt, latch cmd, csum_acc = rx_data, byte count = 0, go to S_DATA.
  - S_DATA: on rx_evt, shift data = {data[23:0], rx_data}, csum_acc ^= rx_data. After the 4th byte go to S_CSUM.
  - S_CSUM: on rx_evt, go to S_EXEC with the chk_ok flag = (rx_data == csum_acc).
  - S_EXEC (exactly 1 cycle):
    - chk_ok and cmd <= MAX_CMD: wr_en = 1, wr_addr = cmd[3:0], wr_data = data; response = ACK.
    - chk_ok and cmd == 15: clear_all = 1; response = ACK.
    - Otherwise: response = NAK and err_cnt increments.
    - Go to S_RESP.
  - S_RESP: wait while tx_busy = 1. On the first cycle with tx_busy = 0, pulse tx_start for 1 cycle with tx_data = response, then go to S_TXW.
  - S_TXW: wait for tx_busy to rise, then fall, then go to S_SYNC.
    - If tx_busy never rises within TIMEOUT cycles, go to S_SYNC anyway.
- Timing:
  - wr_en / clear_all assert exactly 1 cycle after the cycle carrying the CSUM rx_evt.
  - wr_addr and wr_data hold their values until the next write.
  - tx_start asserts no earlier than 1 cycle after wr_en.
- Timeout:
  - In S_CMD, S_DATA and S_CSUM the counter increments every cycle without rx_evt and clears on rx_evt.
  - When the counter reaches TIMEOUT-1: go to S_SYNC, err_cnt increments, no response is sent.
- Bytes arriving in S_EXEC, S_RESP or S_TXW are dropped and not counted.
- A SYNC_BYTE value received inside a frame is treated as data; there is no resync.
- err_cnt saturates at 255 and is cleared only by rst.
- Reset mid-frame or mid-response: immediate return to S_SYNC, all strobes deasserted, no partial write.

Test Plan:
- Frame A5 02 00 01 86 A0 25 (CSUM = 02^00^01^86^A0 = 0x25) -> one wr_en pulse with wr_addr = 2, wr_data = 0x000186A0; tx_start with tx_data = 0x06; err_cnt = 0.
- Same frame with CSUM 0x26 -> no wr_en; tx_data = 0x15; err_cnt = 1.
- Frame A5 0F 00 00 00 00 0F -> clear_all for 1 cycle, ACK; cmd 0x0D with a correct CSUM -> NAK, no write.
- A5 03 then silence of TIMEOUT cycles -> returns to S_SYNC (idle = 1), err_cnt += 1, no tx_start. A following valid frame is accepted normally.
- Two back-to-back valid frames while tx_busy is held high for 50 cycles after the first tx_start -> bytes arriving during S_RESP/S_TXW are dropped, and only the first write occurs.
- rst asserted after the D1 byte -> outputs return to reset values asynchronously and no wr_en occurs; 300 NAK frames -> err_cnt holds at 255.
